// File: rtl/maze_pkg.sv
// Shared types and constants for the maze robot gap-maneuver controller.
package maze_pkg;

  localparam int unsigned CMD_W    = 16;
  localparam int unsigned HDG_W    = 12;
  localparam int unsigned TMR_W    = 23;
  localparam int unsigned GAP_QUAL = 16;

  localparam logic signed [HDG_W-1:0] VEER_ADJ = 12'sd250;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_VEER,
    ST_SETTLE,
    ST_TURN,
    ST_REACQ,
    ST_DONE,
    ST_BUMP
  } state_t;

  typedef enum logic [1:0] {
    CODE_STOP  = 2'b00,
    CODE_RIGHT = 2'b01,
    CODE_LEFT  = 2'b10,
    CODE_TURN  = 2'b11
  } code_t;

  // Heading offset applied while veering for a right or left code.
  function automatic logic signed [HDG_W-1:0] veer_adj(input code_t c);
    return (c == CODE_LEFT) ? -VEER_ADJ : VEER_ADJ;
  endfunction

endpackage

// File: rtl/line_gap_filt.sv
// Qualifies a line gap: asserts o_gap once the line has been absent for
// GAP_QUAL consecutive samples; any line-present sample restarts the count.
module line_gap_filt
  import maze_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_line_present,
  output logic o_gap
);

  localparam int unsigned CNT_W = $clog2(GAP_QUAL + 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturating count of consecutive line-absent samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_line_present) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(GAP_QUAL)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_gap = (r_cnt == CNT_W'(GAP_QUAL));

endmodule

// File: rtl/gap_maneuver_ctrl.sv
// Executes a two-bit-per-gap travel plan: veers, turns around or stops at
// each qualified line gap, with bumper override and one shared timer.
module gap_maneuver_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned FAST_SIM = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CMD_W-1:0]        cmd,
  input  logic                    cmd_rdy,
  input  logic                    line_present,
  input  logic                    BMPL_n,
  input  logic                    BMPR_n,
  output logic                    clr_cmd_rdy,
  output logic                    go,
  output logic signed [HDG_W-1:0] hdg_adj,
  output logic                    spin,
  output logic                    buzz_en,
  output logic                    plan_done
);

  localparam logic [TMR_W-1:0] SETTLE_LAST =
    (FAST_SIM != 0) ? TMR_W'((1 << 10) - 1) : TMR_W'((1 << 20) - 1);
  localparam logic [TMR_W-1:0] TURN_LAST =
    (FAST_SIM != 0) ? TMR_W'((1 << 12) - 1) : TMR_W'((1 << 22) - 1);

  state_t                    r_state;
  logic [CMD_W-1:0]          r_plan;
  logic [TMR_W-1:0]          r_tmr;
  logic                      r_clr;
  logic                      r_go;
  logic signed [HDG_W-1:0]   r_hdg;
  logic                      r_spin;
  logic                      r_buzz;
  logic                      r_done;
  logic                      w_gap;
  logic                      w_bump;
  code_t                     w_code;

  line_gap_filt u_gap_filt (
    .clk            (clk),
    .rst            (rst),
    .i_line_present (line_present),
    .o_gap          (w_gap)
  );

  assign w_bump = ~BMPL_n | ~BMPR_n;
  assign w_code = code_t'(r_plan[1:0]);

  // Maneuver sequencer; a bumper hit overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_plan  <= '0;
      r_tmr   <= '0;
      r_clr   <= 1'b0;
      r_go    <= 1'b0;
      r_hdg   <= '0;
      r_spin  <= 1'b0;
      r_buzz  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_clr <= 1'b0;
      if (w_bump) begin
        r_state <= ST_BUMP;
        r_go    <= 1'b0;
        r_spin  <= 1'b0;
        r_hdg   <= '0;
        r_buzz  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_BUMP: begin
            if (cmd_rdy) begin
              r_state <= ST_FOLLOW;
              r_plan  <= cmd;
              r_clr   <= 1'b1;
              r_go    <= 1'b1;
              r_spin  <= 1'b0;
              r_hdg   <= '0;
              r_buzz  <= 1'b0;
              r_done  <= 1'b0;
            end
          end
          ST_FOLLOW: begin
            if (w_gap) begin
              case (w_code)
                CODE_STOP: begin
                  r_state <= ST_DONE;
                  r_go    <= 1'b0;
                  r_done  <= 1'b1;
                  r_hdg   <= '0;
                end
                CODE_RIGHT, CODE_LEFT: begin
                  r_state <= ST_VEER;
                  r_hdg   <= veer_adj(w_code);
                end
                CODE_TURN: begin
                  r_state <= ST_TURN;
                  r_spin  <= 1'b1;
                  r_go    <= 1'b1;
                  r_hdg   <= '0;
                  r_tmr   <= '0;
                end
                default: r_state <= ST_FOLLOW;
              endcase
            end
          end
          ST_VEER: begin
            if (line_present) begin
              r_state <= ST_SETTLE;
              r_tmr   <= '0;
            end
          end
          ST_SETTLE: begin
            if (r_tmr == SETTLE_LAST) begin
              r_state <= ST_FOLLOW;
              r_hdg   <= '0;
              r_plan  <= r_plan >> 2;
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
          ST_TURN: begin
            if (r_tmr == TURN_LAST) begin
              r_state <= ST_REACQ;
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
          ST_REACQ: begin
            if (line_present) begin
              r_state <= ST_FOLLOW;
              r_spin  <= 1'b0;
              r_plan  <= r_plan >> 2;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign clr_cmd_rdy = r_clr;
  assign go          = r_go;
  assign hdg_adj     = r_hdg;
  assign spin        = r_spin;
  assign buzz_en     = r_buzz;
  assign plan_done   = r_done;

endmodule
